// File: rtl/gol_gen_sequencer.sv
// Game of Life grid owner: sweeps one generation into a shadow grid, commits it,
// then streams every cell to the vga_adapter plot port. Edits land only while idle.
module gol_gen_sequencer #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int X_ORG  = 0,
    parameter int Y_ORG  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        tick,
    input  logic        step,
    input  logic        edit_set,
    input  logic        edit_clr,
    input  logic [7:0]  cur_x,
    input  logic [7:0]  cur_y,
    input  logic [2:0]  alive_colour,
    input  logic [2:0]  dead_colour,
    input  logic [2:0]  cursor_colour,
    output logic        plot,
    output logic [7:0]  plot_x,
    output logic [6:0]  plot_y,
    output logic [2:0]  plot_colour,
    output logic        busy,
    output logic [15:0] gen_count,
    output logic [15:0] pop_count
);
    localparam int N = GRID_W * GRID_H;

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT, DRAW} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] cur_grid_q, cur_grid_d;
    logic [N-1:0] nxt_grid_q, nxt_grid_d;
    logic [7:0]   x_q, x_d, y_q, y_d;
    logic         dirty_q, dirty_d;
    logic [15:0]  acc_q, acc_d, gen_q, gen_d, pop_q, pop_d;
    logic         plot_q, plot_d;
    logic [7:0]   plot_x_q, plot_x_d;
    logic [6:0]   plot_y_q, plot_y_d;
    logic [2:0]   colour_q, colour_d;
    logic         start, edit_ok, last_cell, nxt_alive;

    function automatic int cell_idx(input logic [7:0] x, input logic [7:0] y);
        return int'(y) * GRID_W + int'(x);
    endfunction

    // Cells beyond the grid edge count as dead; there is no toroidal wrap.
    function automatic logic [3:0] live_neighbours(input logic [N-1:0] grid,
                                                   input logic [7:0] x,
                                                   input logic [7:0] y);
        logic [3:0] n;
        int nx, ny;
        n = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(x) + dx;
                ny = int'(y) + dy;
                if ((dx != 0 || dy != 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
                    n = n + {3'd0, grid[ny * GRID_W + nx]};
            end
        end
        return n;
    endfunction

    function automatic logic next_alive(input logic [3:0] n, input logic alive);
        return (n == 4'd3) || (n == 4'd2 && alive);
    endfunction

    always_comb begin
        state_d    = state_q;
        cur_grid_d = cur_grid_q;
        nxt_grid_d = nxt_grid_q;
        x_d        = x_q;
        y_d        = y_q;
        dirty_d    = dirty_q;
        acc_d      = acc_q;
        gen_d      = gen_q;
        pop_d      = pop_q;
        plot_x_d   = plot_x_q;
        plot_y_d   = plot_y_q;
        colour_d   = colour_q;
        nxt_alive  = 1'b0;
        start      = step | (run & tick);
        edit_ok    = (int'(cur_x) < GRID_W) && (int'(cur_y) < GRID_H) && (edit_set != edit_clr);
        last_cell  = (int'(x_q) == GRID_W - 1) && (int'(y_q) == GRID_H - 1);

        case (state_q)
            IDLE: begin
                // The edit lands before the start decision so a same-cycle sweep sees it.
                if (edit_ok) begin
                    cur_grid_d[cell_idx(cur_x, cur_y)] = edit_set;
                    dirty_d = 1'b1;
                end
                if (start) begin
                    state_d = COMPUTE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (dirty_d) begin
                    state_d = DRAW;
                    x_d     = '0;
                    y_d     = '0;
                    dirty_d = 1'b0;
                end
            end
            COMPUTE: begin
                nxt_alive = next_alive(live_neighbours(cur_grid_q, x_q, y_q),
                                       cur_grid_q[cell_idx(x_q, y_q)]);
                nxt_grid_d[cell_idx(x_q, y_q)] = nxt_alive;
                acc_d = acc_q + {15'd0, nxt_alive};
                if (last_cell) state_d = COMMIT;
            end
            COMMIT: begin
                cur_grid_d = nxt_grid_q;
                pop_d      = acc_q;
                gen_d      = gen_q + 16'd1;
                acc_d      = '0;
                state_d    = DRAW;
                x_d        = '0;
                y_d        = '0;
                dirty_d    = 1'b0;
            end
            DRAW: begin
                if (last_cell) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == COMPUTE || state_q == DRAW) && !last_cell) begin
            if (int'(x_q) == GRID_W - 1) begin
                x_d = '0;
                y_d = y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end

        // Plot port is registered, so the pixel is prepared from the next scan position and grid.
        plot_d = (state_d == DRAW);
        if (plot_d) begin
            plot_x_d = 8'(X_ORG + int'(x_d));
            plot_y_d = 7'(Y_ORG + int'(y_d));
            if (x_d == cur_x && y_d == cur_y)
                colour_d = cursor_colour;
            else if (cur_grid_d[cell_idx(x_d, y_d)])
                colour_d = alive_colour;
            else
                colour_d = dead_colour;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_grid_q <= '0;
            nxt_grid_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dirty_q    <= 1'b1;
            acc_q      <= '0;
            gen_q      <= '0;
            pop_q      <= '0;
            plot_q     <= 1'b0;
            plot_x_q   <= '0;
            plot_y_q   <= '0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_grid_q <= cur_grid_d;
            nxt_grid_q <= nxt_grid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dirty_q    <= dirty_d;
            acc_q      <= acc_d;
            gen_q      <= gen_d;
            pop_q      <= pop_d;
            plot_q     <= plot_d;
            plot_x_q   <= plot_x_d;
            plot_y_q   <= plot_y_d;
            colour_q   <= colour_d;
        end
    end

    assign plot        = plot_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = colour_q;
    assign busy        = (state_q != IDLE);
    assign gen_count   = gen_q;
    assign pop_count   = pop_q;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Scoreboarded bench for gol_gen_sequencer: a grid model predicts every plotted
// pixel, the busy window and the generation/population counters.
module tb_gol_gen_sequencer;
    localparam int GW = 10;
    localparam int GH = 10;
    localparam int N  = GW * GH;
    localparam int XO = 4;
    localparam int YO = 2;
    localparam logic [2:0] C_ALIVE = 3'd2;
    localparam logic [2:0] C_DEAD  = 3'd1;
    localparam logic [2:0] C_CUR   = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0, tick = 1'b0, step = 1'b0;
    logic        edit_set = 1'b0, edit_clr = 1'b0;
    logic [7:0]  cur_x = '0, cur_y = '0;
    logic [2:0]  alive_colour = C_ALIVE, dead_colour = C_DEAD, cursor_colour = C_CUR;
    logic        plot, busy;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic [15:0] gen_count, pop_count;

    logic [17:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    bit mdl [GH][GW];
    int mgen = 0;
    int mpop = 0;

    gol_gen_sequencer #(.GRID_W(GW), .GRID_H(GH), .X_ORG(XO), .Y_ORG(YO)) dut (
        .clk(clk), .rst(rst), .run(run), .tick(tick), .step(step),
        .edit_set(edit_set), .edit_clr(edit_clr), .cur_x(cur_x), .cur_y(cur_y),
        .alive_colour(alive_colour), .dead_colour(dead_colour), .cursor_colour(cursor_colour),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy), .gen_count(gen_count), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Pixel monitor: every plot strobe must match the oldest predicted pixel.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            if (exp_q.size() == 0) check_eq("pix_extra", {31'd0, plot}, 32'd0);
            else check_eq("pixel", {14'd0, plot_x, plot_y, plot_colour}, {14'd0, exp_q.pop_front()});
        end
    end

    task automatic model_step();
        bit nxt [GH][GW];
        int n;
        mpop = 0;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                n = 0;
                for (int yy = y - 1; yy <= y + 1; yy++)
                    for (int xx = x - 1; xx <= x + 1; xx++)
                        if (yy >= 0 && yy < GH && xx >= 0 && xx < GW && !(yy == y && xx == x))
                            n += int'(mdl[yy][xx]);
                nxt[y][x] = (n == 3) || (n == 2 && mdl[y][x]);
                mpop += int'(nxt[y][x]);
            end
        end
        mdl  = nxt;
        mgen = (mgen + 1) % 65536;
    endtask

    task automatic push_frame();
        logic [2:0] c;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                if (x == int'(cur_x) && y == int'(cur_y)) c = C_CUR;
                else if (mdl[y][x]) c = C_ALIVE;
                else c = C_DEAD;
                exp_q.push_back({8'(XO + x), 7'(YO + y), c});
            end
        end
    endtask

    // Counts busy cycles from the current cycle on; optionally pokes step or edit_set mid-run.
    task automatic run_busy(input int inject_at, input bit inject_edit, output int cycles);
        cycles = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            @(negedge clk);
            if (busy !== 1'b1) return;
            cycles++;
            if (cycles == inject_at) begin
                if (inject_edit) edit_set = 1'b1;
                else step = 1'b1;
                @(posedge clk); #1;
                edit_set = 1'b0;
                step = 1'b0;
            end
        end
        check_eq("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_quiet(input string tag);
        repeat (5) begin
            @(negedge clk);
            check_eq(tag, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic do_reset(input int x, input int y);
        int cyc;
        rst = 1'b1;
        run = 1'b0; tick = 1'b0; step = 1'b0; edit_set = 1'b0; edit_clr = 1'b0;
        cur_x = 8'(x); cur_y = 8'(y);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_plot", {31'd0, plot}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_gen", gen_count, 0);
        check_eq("rst_pop", pop_count, 0);
        check_eq("rst_pix", {plot_x, plot_y, plot_colour}, 0);
        exp_q.delete();
        for (int yy = 0; yy < GH; yy++)
            for (int xx = 0; xx < GW; xx++) mdl[yy][xx] = 1'b0;
        mgen = 0;
        mpop = 0;
        push_frame();
        rst = 1'b0;
        @(posedge clk); #1;
        run_busy(-1, 1'b0, cyc);
        check_eq("rst_draw_len", cyc, N);
        check_eq("sb_drain", exp_q.size(), 0);
        check_eq("rst_draw_gen", gen_count, 0);
    endtask

    task automatic edit_cell(input int x, input int y, input bit set);
        int cyc;
        bit valid;
        cur_x = 8'(x);
        cur_y = 8'(y);
        valid = (x < GW) && (y < GH);
        if (valid) begin
            mdl[y][x] = set;
            push_frame();
        end
        edit_set = set;
        edit_clr = !set;
        @(posedge clk); #1;
        edit_set = 1'b0;
        edit_clr = 1'b0;
        if (valid) begin
            run_busy(-1, 1'b0, cyc);
            check_eq("edit_draw_len", cyc, N);
            check_eq("sb_drain", exp_q.size(), 0);
        end else begin
            expect_quiet("edit_oob_quiet");
        end
    endtask

    task automatic do_gen(input bit use_tick, input bit with_edit, input int inject_at, input bit inject_edit);
        int cyc;
        if (with_edit) begin
            mdl[cur_y][cur_x] = 1'b1;
            edit_set = 1'b1;
        end
        model_step();
        push_frame();
        if (use_tick) tick = 1'b1;
        else step = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        step = 1'b0;
        edit_set = 1'b0;
        run_busy(inject_at, inject_edit, cyc);
        check_eq("gen_busy_len", cyc, 2 * N + 1);
        check_eq("sb_drain", exp_q.size(), 0);
        check_eq("gen_count", gen_count, mgen);
        check_eq("pop_count", pop_count, mpop);
        check_eq("plot_idle", {31'd0, plot}, 0);
        check_eq("plot_xy_hold", {plot_x, plot_y}, {8'(XO + GW - 1), 7'(YO + GH - 1)});
    endtask

    initial begin
        // Reset draw: every cell dead, cursor at (0,0).
        do_reset(0, 0);

        // Vertical blinker flips to horizontal and back.
        edit_cell(4, 3, 1'b1);
        edit_cell(4, 4, 1'b1);
        edit_cell(4, 5, 1'b1);
        do_gen(1'b0, 1'b0, -1, 1'b0);
        check_eq("blinker_pop1", pop_count, 3);
        check_eq("blinker_gen1", gen_count, 1);
        do_gen(1'b0, 1'b0, -1, 1'b0);
        check_eq("blinker_gen2", gen_count, 2);

        // Tick without run does nothing; both edit strobes together write nothing.
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        expect_quiet("tick_no_run_quiet");
        cur_x = 8'd6; cur_y = 8'd6;
        edit_set = 1'b1; edit_clr = 1'b1;
        @(posedge clk); #1;
        edit_set = 1'b0; edit_clr = 1'b0;
        expect_quiet("edit_both_quiet");

        // Corner block under paced free-run evolution stays put.
        do_reset(0, 0);
        edit_cell(0, 0, 1'b1);
        edit_cell(1, 0, 1'b1);
        edit_cell(0, 1, 1'b1);
        edit_cell(1, 1, 1'b1);
        run = 1'b1;
        for (int t = 0; t < 5; t++) begin
            do_gen(1'b1, 1'b0, -1, 1'b0);
            repeat (99) @(posedge clk);
            #1;
        end
        run = 1'b0;
        check_eq("block_gen", gen_count, 5);
        check_eq("block_pop", pop_count, 4);
        edit_cell(1, 1, 1'b0);

        // Out-of-range edit, same-cycle edit+step, edit dropped during COMPUTE.
        edit_cell(12, 2, 1'b1);
        do_reset(0, 0);
        edit_cell(2, 2, 1'b1);
        edit_cell(3, 2, 1'b1);
        cur_x = 8'd4; cur_y = 8'd2;
        do_gen(1'b0, 1'b1, -1, 1'b0);
        check_eq("edit_step_pop", pop_count, 3);
        cur_x = 8'd4; cur_y = 8'd3;
        expect_quiet("cursor_move_quiet");
        do_gen(1'b0, 1'b0, 10, 1'b1);
        check_eq("edit_drop_pop", pop_count, 3);
        check_eq("edit_drop_gen", gen_count, 2);

        // Reset 50 cycles into a sweep aborts it with no commit.
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check_eq("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 0);
        check_eq("abort_gen", gen_count, 0);
        do_reset(0, 0);

        // Step while busy is ignored: one generation, IDLE at cycle 2N+2.
        edit_cell(4, 3, 1'b1);
        edit_cell(4, 4, 1'b1);
        edit_cell(4, 5, 1'b1);
        do_gen(1'b0, 1'b0, 20, 1'b0);
        check_eq("busy_step_gen", gen_count, 1);
        expect_quiet("after_gen_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
